nios_pio_write_arbiter: RTL and testbench
=========================================

Name: nios_pio_write_arbiter

Overview:
- Round-robin arbiter that shares the single Avalon-MM write path of the 3-bit output PIO (s1 slave: address, chipselect, write_n, writedata) between NREQ independent requesters.
- Each requester presents a level request with payload data. The arbiter issues one zero-wait-state write to PIO address 0, acknowledges the winner with a one-cycle grant pulse, then enforces a programmable dwell gap before the next write.
- Sits between the custom logic masters and the PIO slave port in the Nios system.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 3, PIO data width; payload bits written to writedata[DW-1:0].
- MIN_GAP, 2, idle cycles enforced after each write before the next arbitration (0..255).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous active-low reset.
- req  input  NREQ  per-requester level request; held until own gnt bit pulses.
- req_data  input  NREQ*DW  payload; requester i occupies bits [i*DW +: DW]; stable while req[i]=1.
- gnt  output  NREQ  one-hot pulse; high exactly in the cycle requester i's write is on the bus.
- m_address  output  2  PIO address; always 0 during a write, 0 otherwise.
- m_chipselect  output  1  PIO chipselect.
- m_write_n  output  1  PIO active-low write strobe.
- m_writedata  output  32  {(32-DW)'b0, payload}.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: single clock clk. Reset reset_n is synchronous and active-low, sampled only on the rising edge of clk.
- Reset values: gnt=0, m_address=0, m_chipselect=0, m_write_n=1, m_writedata=0, busy=0, priority pointer=0, gap counter=0, state=IDLE.
- All outputs are registered.
- State IDLE:
  - If any req bit is set, select the winner by round-robin starting at the pointer: the first set req[k], with k = pointer, pointer+1, ... mod NREQ.
  - On the next edge: state=ISSUE, m_chipselect=1, m_write_n=0, m_writedata=winner payload zero-extended, gnt[winner]=1, pointer=(winner+1) mod NREQ.
  - If no req bit is set, remain in IDLE with outputs deasserted.
- State ISSUE: lasts exactly 1 cycle, because the PIO accepts writes with zero wait states.
  - On the next edge, deassert m_chipselect, m_write_n (back to 1) and gnt.
  - m_writedata returns to 0.
  - If MIN_GAP=0, go to IDLE; otherwise go to GAP and load the counter with MIN_GAP-1.
- State GAP: the counter decrements each cycle. When the counter is 0, the next state is IDLE. Requests are not sampled in GAP.
- Latency: 1 cycle from req sampled high in IDLE to the write on the bus. Back-to-back write period is 2+MIN_GAP cycles.
- Requester protocol:
  - Drop req[i] in the cycle after gnt[i] is seen; the arbiter does not sample req in ISSUE or GAP.
  - A requester still holding req when the arbiter returns to IDLE gets another write.
- Withdrawal: req[i] may drop before grant without penalty. Only the IDLE-cycle sample matters.
- Simultaneous requests: exactly one winner per arbitration. Losers wait. With every requester requesting continuously, each is granted once per NREQ writes.
- A payload change during ISSUE does not affect the captured write.
- Reset asserted mid-ISSUE or mid-GAP: on the next edge all outputs take reset values and the in-flight write is abandoned. The bus never shows chipselect=1 in the cycle after reset is sampled low.
- Invariants:
  - m_chipselect=1 if and only if m_write_n=0 if and only if gnt is nonzero.
  - gnt is always one-hot or zero.

Optional Feature:
- Macro: NIOS_PIO_ARB_SHADOW_EN.
- Defined:
  - Adds output shadow_out [DW], which holds the last value written to the PIO (reset 0, updated in the ISSUE cycle).
  - If the winner's payload equals shadow_out, the arbiter still pulses gnt[winner] for one cycle. During that cycle m_chipselect=0 and m_write_n=1, so no bus write occurs.
  - The pointer advance and GAP sequencing are unchanged.
- Undefined: no shadow_out port, and every grant performs a bus write.

Test Plan:
- Reset then idle: hold reset_n=0 for 3 cycles, then req=0 for 10 cycles -> m_chipselect=0, m_write_n=1, gnt=0, busy=0 throughout.
- Single request: req=4'b0010, req_data[5:3]=3'b101 -> next cycle m_chipselect=1, m_write_n=0, m_address=0, m_writedata=32'h5, gnt=4'b0010. Then with MIN_GAP=2, busy=1 for 3 cycles total.
- Round-robin fairness: req=4'b1111 held continuously -> grant order 0,1,2,3,0,... Writes are 4 cycles apart with MIN_GAP=2.
- Pointer wrap: pointer=3 after granting requester 2, then req=4'b1001 -> requester 3 is granted first, then requester 0.
- Reset mid-operation: assert reset_n=0 in the ISSUE cycle -> next edge m_chipselect=0, gnt=0. After release, the first grant goes to the lowest set index because the pointer is back at 0.
- Shadow (macro defined): write 3'b011, then the same requester requests 3'b011 -> gnt pulses with m_chipselect=0, and shadow_out stays 3'b011.

Source files
------------

// File: rtl/nios_pio_write_arbiter.sv
// Round-robin arbiter sharing the PIO s1 write path between NREQ requesters.
// Optional NIOS_PIO_ARB_SHADOW_EN adds shadow_out and suppresses redundant bus writes.
module nios_pio_write_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 3,
    parameter int MIN_GAP = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [1:0]         m_address,
    output logic               m_chipselect,
    output logic               m_write_n,
    output logic [31:0]        m_writedata,
`ifdef NIOS_PIO_ARB_SHADOW_EN
    output logic [DW-1:0]      shadow_out,
`endif
    output logic               busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [7:0]      gap_cnt, cnt_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic            cs_q, cs_nxt;
    logic [DW-1:0]   wdata_q, wdata_nxt;
    logic [DW-1:0]   shadow_q, shadow_nxt;
    logic            found;
    logic [PW-1:0]   win, idx;
    logic [DW-1:0]   payload;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int j = 0; j < NREQ; j++) begin
            idx = PW'((int'(ptr) + j) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        payload = req_data[int'(win)*DW +: DW];
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        cnt_nxt    = gap_cnt;
        gnt_nxt    = '0;
        cs_nxt     = 1'b0;
        wdata_nxt  = '0;
        shadow_nxt = shadow_q;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt    = ISSUE;
                    gnt_nxt[win] = 1'b1;
                    cs_nxt       = 1'b1;
                    wdata_nxt    = payload;
                    ptr_nxt      = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
`ifdef NIOS_PIO_ARB_SHADOW_EN
                    // PIO already holds this value: grant the requester but skip the bus write
                    if (payload == shadow_q) begin
                        cs_nxt    = 1'b0;
                        wdata_nxt = '0;
                    end
`endif
                    shadow_nxt   = payload;
                end
            end
            ISSUE: begin
                if (MIN_GAP == 0) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = GAP;
                    cnt_nxt   = 8'(MIN_GAP - 1);
                end
            end
            GAP: begin
                if (gap_cnt == 8'd0) state_nxt = IDLE;
                else                 cnt_nxt   = gap_cnt - 8'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gap_cnt   <= '0;
            gnt       <= '0;
            cs_q      <= 1'b0;
            m_write_n <= 1'b1;
            wdata_q   <= '0;
            shadow_q  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gap_cnt   <= cnt_nxt;
            gnt       <= gnt_nxt;
            cs_q      <= cs_nxt;
            m_write_n <= ~cs_nxt;
            wdata_q   <= wdata_nxt;
            shadow_q  <= shadow_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

    assign m_chipselect = cs_q;
    assign m_address    = 2'b00;
    assign m_writedata  = {{(32-DW){1'b0}}, wdata_q};
`ifdef NIOS_PIO_ARB_SHADOW_EN
    assign shadow_out   = shadow_q;
`endif

endmodule

// File: tb/tb_nios_pio_write_arbiter.sv
// Randomized bench for nios_pio_write_arbiter against a timing/round-robin reference model.
module tb_nios_pio_write_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 3;
    localparam int MIN_GAP = 2;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [1:0]         m_address;
    logic               m_chipselect;
    logic               m_write_n;
    logic [31:0]        m_writedata;
    logic               busy;
`ifdef NIOS_PIO_ARB_SHADOW_EN
    logic [DW-1:0]      shadow_out;
`endif

    nios_pio_write_arbiter #(.NREQ(NREQ), .DW(DW), .MIN_GAP(MIN_GAP)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .req_data     (req_data),
        .gnt          (gnt),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
`ifdef NIOS_PIO_ARB_SHADOW_EN
        .shadow_out   (shadow_out),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: next cycle at which arbitration may happen, rotating pointer
    int            cyc     = 0;
    int            free_at = 0;
    int            mptr    = 0;
    int            last_w  = -1;
    logic [DW-1:0] mshadow = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input logic rst_i, input logic [NREQ-1:0] r, input logic [NREQ*DW-1:0] d);
        logic [NREQ-1:0] e_gnt;
        logic            e_cs;
        logic [DW-1:0]   e_data;
        logic [DW-1:0]   pl;
        logic            e_busy;
        int              w;
        reset_n  = rst_i;
        req      = r;
        req_data = d;
        @(posedge clk);
        cyc++;
        e_gnt  = '0;
        e_cs   = 1'b0;
        e_data = '0;
        last_w = -1;
        if (!rst_i) begin
            free_at = cyc + 1;
            mptr    = 0;
            mshadow = '0;
        end else if (cyc >= free_at && r != '0) begin
            w = -1;
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && r[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
            pl        = d[w*DW +: DW];
            e_gnt[w]  = 1'b1;
            e_cs      = 1'b1;
            e_data    = pl;
`ifdef NIOS_PIO_ARB_SHADOW_EN
            if (pl == mshadow) begin
                e_cs   = 1'b0;
                e_data = '0;
            end
`endif
            mshadow = pl;
            mptr    = (w + 1) % NREQ;
            free_at = cyc + 2 + MIN_GAP;
            last_w  = w;
        end
        e_busy = rst_i && (cyc + 1 < free_at);
        #1;
        chk("gnt",       64'(gnt),          64'(e_gnt));
        chk("cs",        64'(m_chipselect), 64'(e_cs));
        chk("write_n",   64'(m_write_n),    64'(!e_cs));
        chk("writedata", 64'(m_writedata),  64'(e_data));
        chk("address",   64'(m_address),    64'd0);
        chk("busy",      64'(busy),         64'(e_busy));
`ifdef NIOS_PIO_ARB_SHADOW_EN
        chk("shadow",    64'(shadow_out),   64'(mshadow));
`endif
    endtask

    logic [NREQ-1:0]    rq;
    logic [NREQ*DW-1:0] rd;
    int                 order[$];

    initial begin
        reset_n  = 1'b0;
        req      = '0;
        req_data = '0;

        // reset then idle
        repeat (3) step(1'b0, '0, '0);
        repeat (10) step(1'b1, '0, '0);

        // single request from requester 1 with payload 5
        step(1'b1, 4'b0010, 12'b000_000_101_000);
        chk("single_gnt",  64'(gnt),         64'h2);
        chk("single_data", 64'(m_writedata), 64'h5);
        step(1'b1, '0, '0);
        chk("single_busy_issue_end", 64'(busy), 64'd1);
        step(1'b1, '0, '0);
        chk("single_busy_gap", 64'(busy), 64'd1);
        step(1'b1, '0, '0);
        chk("single_busy_done", 64'(busy), 64'd0);

        // fairness: all request continuously from a fresh reset
        step(1'b0, '0, '0);
        order.delete();
        for (int c = 0; c < 32; c++) begin
            step(1'b1, 4'b1111, 12'o1234);
            if (gnt != '0) order.push_back(last_w);
        end
        chk("rr_count", 64'(order.size()), 64'd8);
        for (int i = 0; i < order.size(); i++) chk("rr_order", 64'(order[i]), 64'(i % NREQ));

        // pointer wrap: grant 2 leaves pointer at 3, then 4'b1001 -> 3 then 0
        step(1'b0, '0, '0);
        step(1'b1, 4'b0100, 12'o0600);
        chk("wrap_first", 64'(gnt), 64'h4);
        repeat (3) step(1'b1, '0, '0);
        step(1'b1, 4'b1001, 12'o7001);
        chk("wrap_to3", 64'(gnt), 64'h8);
        repeat (3) step(1'b1, 4'b0001, 12'o0001);
        step(1'b1, 4'b0001, 12'o0001);
        chk("wrap_to0", 64'(gnt), 64'h1);
        repeat (3) step(1'b1, '0, '0);

        // reset in ISSUE cycle abandons the write and clears the pointer
        step(1'b1, 4'b0100, 12'o0300);
        chk("mid_issue", 64'(m_chipselect), 64'd1);
        step(1'b0, 4'b0100, 12'o0300);
        chk("rst_cs",  64'(m_chipselect), 64'd0);
        chk("rst_gnt", 64'(gnt),          64'd0);
        step(1'b1, 4'b0110, 12'o0340);
        chk("post_rst_gnt", 64'(gnt), 64'h2);
        repeat (3) step(1'b1, '0, '0);

`ifdef NIOS_PIO_ARB_SHADOW_EN
        step(1'b1, 4'b0001, 12'o0003);
        chk("sh_write", 64'(m_chipselect), 64'd1);
        repeat (3) step(1'b1, '0, '0);
        step(1'b1, 4'b0001, 12'o0003);
        chk("sh_gnt",  64'(gnt),          64'h1);
        chk("sh_cs",   64'(m_chipselect), 64'd0);
        chk("sh_val",  64'(shadow_out),   64'h3);
        repeat (3) step(1'b1, '0, '0);
`endif

        // random traffic; data only changes while the requester's req is low
        rq = '0;
        rd = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rq[i]) begin
                    if ((gnt[i] && $urandom_range(9) < 7) || $urandom_range(19) == 0) rq[i] = 1'b0;
                end else if ($urandom_range(9) < 3) begin
                    rq[i] = 1'b1;
                    rd[i*DW +: DW] = DW'($urandom);
                end
            end
            step(($urandom_range(199) != 0), rq, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
